maxpool2x2_16ch: RTL



---
 rtl/maxpool2x2_16ch.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/maxpool2x2_16ch.sv
// Streaming 2x2 / stride-2 max pool over 16 IEEE-754 channels, raster order in and out.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to +0 (fused ReLU).
module maxpool2x2_16ch #(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 112,
    parameter int HEIGHT = 112
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] data_in_0,
    input  logic [DWIDTH-1:0] data_in_1,
    input  logic [DWIDTH-1:0] data_in_2,
    input  logic [DWIDTH-1:0] data_in_3,
    input  logic [DWIDTH-1:0] data_in_4,
    input  logic [DWIDTH-1:0] data_in_5,
    input  logic [DWIDTH-1:0] data_in_6,
    input  logic [DWIDTH-1:0] data_in_7,
    input  logic [DWIDTH-1:0] data_in_8,
    input  logic [DWIDTH-1:0] data_in_9,
    input  logic [DWIDTH-1:0] data_in_10,
    input  logic [DWIDTH-1:0] data_in_11,
    input  logic [DWIDTH-1:0] data_in_12,
    input  logic [DWIDTH-1:0] data_in_13,
    input  logic [DWIDTH-1:0] data_in_14,
    input  logic [DWIDTH-1:0] data_in_15,
    input  logic              data_valid_in,
    output logic [DWIDTH-1:0] data_out_0,
    output logic [DWIDTH-1:0] data_out_1,
    output logic [DWIDTH-1:0] data_out_2,
    output logic [DWIDTH-1:0] data_out_3,
    output logic [DWIDTH-1:0] data_out_4,
    output logic [DWIDTH-1:0] data_out_5,
    output logic [DWIDTH-1:0] data_out_6,
    output logic [DWIDTH-1:0] data_out_7,
    output logic [DWIDTH-1:0] data_out_8,
    output logic [DWIDTH-1:0] data_out_9,
    output logic [DWIDTH-1:0] data_out_10,
    output logic [DWIDTH-1:0] data_out_11,
    output logic [DWIDTH-1:0] data_out_12,
    output logic [DWIDTH-1:0] data_out_13,
    output logic [DWIDTH-1:0] data_out_14,
    output logic [DWIDTH-1:0] data_out_15,
    output logic              data_valid_out,
    output logic              frame_done
);
    localparam int NCH    = 16;
    localparam int HALF_W = WIDTH / 2;
    localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    // Handshake: data_valid_in qualifies each input pixel and there is no ready,
    // so every valid pixel is consumed. data_valid_out is a one-cycle strobe;
    // data_out_* hold their last pooled value between strobes.

    logic [NCH-1:0][DWIDTH-1:0] din;
    logic [NCH-1:0][DWIDTH-1:0] dout;
    logic [NCH-1:0][DWIDTH-1:0] hmax;
    logic [NCH-1:0][DWIDTH-1:0] pair_max;
    logic [NCH-1:0][DWIDTH-1:0] pool_max;
    logic [NCH-1:0][DWIDTH-1:0] pooled;
    logic [DWIDTH-1:0]          linebuf [NCH][HALF_W];

    logic [15:0]      col;
    logic [15:0]      row;
    logic             col_odd;
    logic             row_odd;
    logic             col_last;
    logic             row_last;
    logic             window_done;
    logic [LB_AW-1:0] lb_addr;

    assign din[0]  = data_in_0;
    assign din[1]  = data_in_1;
    assign din[2]  = data_in_2;
    assign din[3]  = data_in_3;
    assign din[4]  = data_in_4;
    assign din[5]  = data_in_5;
    assign din[6]  = data_in_6;
    assign din[7]  = data_in_7;
    assign din[8]  = data_in_8;
    assign din[9]  = data_in_9;
    assign din[10] = data_in_10;
    assign din[11] = data_in_11;
    assign din[12] = data_in_12;
    assign din[13] = data_in_13;
    assign din[14] = data_in_14;
    assign din[15] = data_in_15;

    assign data_out_0  = dout[0];
    assign data_out_1  = dout[1];
    assign data_out_2  = dout[2];
    assign data_out_3  = dout[3];
    assign data_out_4  = dout[4];
    assign data_out_5  = dout[5];
    assign data_out_6  = dout[6];
    assign data_out_7  = dout[7];
    assign data_out_8  = dout[8];
    assign data_out_9  = dout[9];
    assign data_out_10 = dout[10];
    assign data_out_11 = dout[11];
    assign data_out_12 = dout[12];
    assign data_out_13 = dout[13];
    assign data_out_14 = dout[14];
    assign data_out_15 = dout[15];

    // Sign-magnitude ordering of IEEE-754 bit patterns; ties keep a, +0 beats -0.
    function automatic logic [DWIDTH-1:0] fp_max(input logic [DWIDTH-1:0] a,
                                                 input logic [DWIDTH-1:0] b);
        logic b_wins;
        if (a[DWIDTH-1] != b[DWIDTH-1]) begin
            b_wins = a[DWIDTH-1];
        end else if (!a[DWIDTH-1]) begin
            b_wins = (b > a);
        end else begin
            b_wins = (b < a);
        end
        return b_wins ? b : a;
    endfunction

    assign col_odd     = col[0];
    assign row_odd     = row[0];
    assign col_last    = (col == 16'(WIDTH - 1));
    assign row_last    = (row == 16'(HEIGHT - 1));
    assign window_done = data_valid_in && col_odd && row_odd;
    assign lb_addr     = LB_AW'(col >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (data_valid_in) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? 16'd0 : row + 16'd1;
            end else begin
                col <= col + 16'd1;
            end
        end
    end

    always_comb begin
        pair_max = '0;
        pool_max = '0;
        pooled   = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            pair_max[ch] = fp_max(hmax[ch], din[ch]);
            pool_max[ch] = fp_max(pair_max[ch], linebuf[ch][lb_addr]);
`ifdef MAXPOOL_RELU_EN
            pooled[ch]   = pool_max[ch][DWIDTH-1] ? '0 : pool_max[ch];
`else
            pooled[ch]   = pool_max[ch];
`endif
        end
    end

    // Window storage needs no reset: even columns and even rows overwrite it before use.
    always_ff @(posedge clk) begin
        if (data_valid_in) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (!col_odd) begin
                    hmax[ch] <= din[ch];
                end else if (!row_odd) begin
                    linebuf[ch][lb_addr] <= pair_max[ch];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout           <= '0;
            data_valid_out <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            frame_done     <= 1'b0;
            if (window_done) begin
                dout           <= pooled;
                data_valid_out <= 1'b1;
                frame_done     <= col_last && row_last;
            end
        end
    end

endmodule
